// File: rtl/reg_wb_arbiter.sv
`default_nettype none
// ============================================================================
// reg_wb_arbiter : merges ALU and long-latency result streams onto the single
//                  register-file write port, with stale-write kill and a
//                  pending-destination mask for decode stalls.
// Revision: 1.0
// ============================================================================
module reg_wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_addr,
  input  logic [31:0] alu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_addr,
  input  logic [31:0] lsu_data,
  output logic        alu_stall,
  output logic [31:0] pending_mask,
  output logic        REG_write_1,
  output logic [4:0]  REG_address_wr,
  output logic [31:0] REG_data_wb_in1
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]       addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [4:0]       addr_n [DEPTH];
  logic [DEPTH-1:0] live_q, live_d;
  logic [AW-1:0]    rp_q, wp_q;
  logic [AW:0]      cnt_q;
  logic [CW-1:0]    starve_q;
  logic [31:0]      pend_q, pend_d;
  logic             we_q;
  logic [4:0]       wa_q;
  logic [31:0]      wd_q;

  logic alu_fire, head_vld, head_live, issue_head, pop, enq;

  assign alu_fire   = alu_valid && (alu_addr != 5'd0);
  assign head_vld   = (cnt_q != '0);
  assign head_live  = head_vld && live_q[rp_q];
  assign issue_head = head_live && !alu_fire;
  // A dead head is always discarded; a live head only leaves when it wins.
  assign pop        = head_vld && (!head_live || !alu_fire);
  assign lsu_ready  = (cnt_q < (AW+1)'(DEPTH));
  assign enq        = lsu_valid && lsu_ready && (lsu_addr != 5'd0);

  always_comb begin
    live_d = live_q;
    addr_n = addr_q;
    if (alu_fire) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (addr_q[i] == alu_addr) live_d[i] = 1'b0;
      end
    end
    if (pop) live_d[rp_q] = 1'b0;
    if (enq) begin
      live_d[wp_q] = !(alu_fire && (alu_addr == lsu_addr));
      addr_n[wp_q] = lsu_addr;
    end
    pend_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_d[i]) pend_d = pend_d | (32'd1 << addr_n[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[wp_q] <= lsu_addr;
      data_q[wp_q] <= lsu_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_q   <= '0;
      rp_q     <= '0;
      wp_q     <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      pend_q   <= '0;
      we_q     <= 1'b0;
      wa_q     <= 5'd0;
      wd_q     <= 32'd0;
    end else begin
      live_q <= live_d;
      pend_q <= pend_d;
      if (enq) wp_q <= wp_q + AW'(1);
      if (pop) rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(enq) - (AW+1)'(pop);
      if (head_live && alu_fire) begin
        if (starve_q < CW'(STARVE_LIMIT)) starve_q <= starve_q + CW'(1);
      end else begin
        starve_q <= '0;
      end
      if (alu_fire) begin
        we_q <= 1'b1;
        wa_q <= alu_addr;
        wd_q <= alu_data;
      end else if (issue_head) begin
        we_q <= 1'b1;
        wa_q <= addr_q[rp_q];
        wd_q <= data_q[rp_q];
      end else begin
        we_q <= 1'b0;
      end
    end
  end

  assign alu_stall       = (starve_q >= CW'(STARVE_LIMIT));
  assign pending_mask    = pend_q;
  assign REG_write_1     = we_q;
  assign REG_address_wr  = wa_q;
  assign REG_data_wb_in1 = wd_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_wb_arbiter.sv
`default_nettype none
// Scoreboard bench for reg_wb_arbiter: a queue-based reference model predicts
// each cycle's write port, and a monitor compares the registered outputs.
module tb_reg_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, lsu_valid, lsu_ready, alu_stall, REG_write_1;
  logic [4:0]  alu_addr, lsu_addr, REG_address_wr;
  logic [31:0] alu_data, lsu_data, pending_mask, REG_data_wb_in1;

  reg_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr), .lsu_data(lsu_data),
    .alu_stall(alu_stall), .pending_mask(pending_mask),
    .REG_write_1(REG_write_1), .REG_address_wr(REG_address_wr), .REG_data_wb_in1(REG_data_wb_in1)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] a; logic [31:0] d; bit live; } ent_t;
  typedef struct { logic we; logic [4:0] a; logic [31:0] d; } exp_t;

  ent_t mq[$];
  exp_t eq[$];
  int   starve;
  logic [4:0]  last_a;
  logic [31:0] last_d;
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    m = '0;
    foreach (mq[i]) if (mq[i].live) m[mq[i].a] = 1'b1;
    return m;
  endfunction

  task automatic cyc(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                     input bit lv, input logic [4:0] la, input logic [31:0] ld);
    bit   rdy, fire, hv, hl;
    exp_t e;
    @(negedge clk);
    chk("pending_mask", pending_mask, model_mask());
    chk("lsu_ready", 32'(lsu_ready), 32'(mq.size() < DEPTH));
    chk("alu_stall", 32'(alu_stall), 32'(starve >= LIMIT));
    if (starve >= LIMIT) av = 1'b0;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    lsu_valid = lv; lsu_addr = la; lsu_data = ld;
    rdy  = (mq.size() < DEPTH);
    fire = av && (aa != 5'd0);
    hv   = (mq.size() > 0);
    hl   = hv && mq[0].live;
    e = '{1'b0, last_a, last_d};
    if (fire)    e = '{1'b1, aa, ad};
    else if (hl) e = '{1'b1, mq[0].a, mq[0].d};
    if (hv && (!hl || !fire)) void'(mq.pop_front());
    starve = (hl && fire) ? starve + 1 : 0;
    if (fire) foreach (mq[i]) if (mq[i].a == aa) mq[i].live = 1'b0;
    if (lv && rdy && (la != 5'd0)) mq.push_back('{la, ld, !(fire && (aa == la))});
    if (e.we) begin last_a = e.a; last_d = e.d; end
    eq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    alu_valid = 0; alu_addr = 0; alu_data = 0;
    lsu_valid = 0; lsu_addr = 0; lsu_data = 0;
    #1;
    chk("rst_write", 32'(REG_write_1), 32'd0);
    chk("rst_addr", 32'(REG_address_wr), 32'd0);
    chk("rst_data", REG_data_wb_in1, 32'd0);
    chk("rst_stall", 32'(alu_stall), 32'd0);
    chk("rst_mask", pending_mask, 32'd0);
    chk("rst_ready", 32'(lsu_ready), 32'd1);
    mq.delete(); eq.delete();
    starve = 0; last_a = '0; last_d = '0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: one expected write-port state per cycle, compared after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (alu_valid) chk("alu_stall_protocol", 32'(alu_stall), 32'd0);
      #1;
      if (eq.size() > 0) begin
        e = eq.pop_front();
        chk("REG_write_1", 32'(REG_write_1), 32'(e.we));
        chk("REG_address_wr", 32'(REG_address_wr), 32'(e.a));
        chk("REG_data_wb_in1", REG_data_wb_in1, e.d);
      end
    end
  end

  initial begin
    rst = 1'b0;
    #2;
    do_reset(2);

    // ALU only
    cyc(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0);
    idle(2);
    // LSU while ALU idle
    cyc(0, 5'd0, 32'd0, 1, 5'd7, 32'h11);
    idle(3);
    // fill FIFO under ALU traffic until starvation, then drain
    for (int k = 0; k < 14; k++)
      cyc(1, 5'd1, 32'h100 + k, k < 4, 5'(10 + k), 32'hA0 + k);
    idle(6);
    // stale LSU overtaken by ALU
    cyc(0, 5'd0, 32'd0, 1, 5'd9, 32'hAA);
    cyc(1, 5'd9, 32'hBB, 0, 5'd0, 32'd0);
    idle(3);
    cyc(1, 5'd2, 32'h22, 1, 5'd9, 32'hAA);
    cyc(1, 5'd9, 32'hBB, 0, 5'd0, 32'd0);
    idle(3);
    // same-cycle collision and r0 traffic
    cyc(1, 5'd3, 32'h333, 1, 5'd3, 32'h444);
    cyc(1, 5'd0, 32'h55, 1, 5'd0, 32'h66);
    idle(4);
    // reset with live entries
    for (int k = 0; k < 3; k++) cyc(1, 5'd1, 32'h7 + k, 1, 5'(20 + k), 32'hC0 + k);
    do_reset(2);
    idle(5);

    // randomized traffic on a small register range to provoke kills
    for (int k = 0; k < 400; k++)
      cyc($urandom_range(0, 99) < 55, 5'($urandom_range(0, 7)), $urandom,
          $urandom_range(0, 99) < 50, 5'($urandom_range(0, 7)), $urandom);
    idle(12);

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_empty", 32'(eq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
